// File: rtl/fifo_pkt_drain_if.sv
// fifo_pkt_drain_if: FIFO pop side and out_wr/out_rdy bus of the drain stage.
// slave is the drain stage's view; master is the FIFO/downstream side.
interface fifo_pkt_drain_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
  logic                             fifo_empty;
  logic                             fifo_rd_en;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_wr;
  logic                             out_rdy;

  modport master (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en,
    input  out_data,
    input  out_ctrl,
    input  out_wr,
    output out_rdy
  );

  modport slave (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en,
    output out_data,
    output out_ctrl,
    output out_wr,
    input  out_rdy
  );
endinterface

// File: rtl/fifo_pkt_drain.sv
// fifo_pkt_drain: framing-aware drain stage behind a FWFT FIFO.
// Statistics counters are built only with FIFO_PKT_DRAIN_STATS_EN.
module fifo_pkt_drain #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] HDR_CTRL   = 8'hFF,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_pkt_drain_if.slave      bus,
  output logic                 in_pkt,
  output logic                 pkt_done,
  output logic                 err,
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  is_hdr;
  logic                  is_data;
  logic                  is_eop;
  logic                  discard;
  logic                  pop;
  logic                  fwd;
  logic                  done_nxt;
  logic                  err_nxt;
  logic                  drop_nxt;

  assign head_ctrl =
    bus.fifo_dout[CTRL_WIDTH+DATA_WIDTH-1 -: CTRL_WIDTH];
  assign head_data = bus.fifo_dout[DATA_WIDTH-1:0];

  assign is_hdr  = (head_ctrl == HDR_CTRL);
  assign is_data = (head_ctrl == '0);
  assign is_eop  = !is_hdr && !is_data;

  // Outside a packet only a header is worth keeping.
  assign discard = ((state == IDLE) || (state == DROP))
                   && !is_hdr;

  // Discards drain regardless of downstream backpressure.
  assign pop = !reset && !bus.fifo_empty
               && (bus.out_rdy || discard);
  assign fwd = pop && !discard;

  assign bus.fifo_rd_en = pop;
  assign in_pkt = (state == HDR) || (state == PAYLOAD);

  // State register; reset returns to IDLE so a cut packet is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Framing FSM: next state plus done/error/drop events for the pop.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    drop_nxt  = 1'b0;
    if (pop) begin
      case (state)
        IDLE: begin
          unique case (1'b1)
            is_hdr: begin
              state_nxt = HDR;
            end
            is_data: begin
              state_nxt = DROP;
              err_nxt   = 1'b1;
              drop_nxt  = 1'b1;
            end
            is_eop: begin
              state_nxt = IDLE;
              err_nxt   = 1'b1;
              drop_nxt  = 1'b1;
            end
          endcase
        end
        HDR: begin
          unique case (1'b1)
            is_hdr:  state_nxt = HDR;
            is_data: state_nxt = PAYLOAD;
            is_eop: begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          endcase
        end
        PAYLOAD: begin
          unique case (1'b1)
            is_hdr: begin
              state_nxt = HDR;
              err_nxt   = 1'b1;
            end
            is_data: state_nxt = PAYLOAD;
            is_eop: begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          endcase
        end
        DROP: begin
          unique case (1'b1)
            is_hdr:  state_nxt = HDR;
            is_data: state_nxt = DROP;
            is_eop:  state_nxt = IDLE;
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output register: one-cycle latency from pop to out_wr.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_wr   <= 1'b0;
      bus.out_data <= '0;
      bus.out_ctrl <= '0;
      pkt_done     <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.out_wr <= fwd;
      pkt_done   <= done_nxt;
      err        <= err_nxt;
      if (fwd) begin
        bus.out_data <= head_data;
        bus.out_ctrl <= head_ctrl;
      end
    end
  end

`ifdef FIFO_PKT_DRAIN_STATS_EN
  // Statistics; a clear wins over any same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      pkt_cnt  <= '0;
      word_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (done_nxt) begin
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
      if (fwd) begin
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
      if (drop_nxt) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = stats_clr ^ drop_nxt;
  assign pkt_cnt  = '0;
  assign word_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// tb_fifo_pkt_drain: directed vector table plus hand sequences
// for the packet drain stage (counters checked with CNT_WIDTH=4).
module tb_fifo_pkt_drain;

`ifdef FIFO_PKT_DRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        emp;
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        rdy;
    logic        e_rd;
    logic        e_wr;
    logic        e_done;
    logic        e_err;
    logic        e_inp;
    logic        ck;
    int          pc;
    int          wc;
    int          dc;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       stats_clr;
  logic       in_pkt;
  logic       pkt_done;
  logic       err;
  logic [3:0] pkt_cnt;
  logic [3:0] word_cnt;
  logic [3:0] drop_cnt;

  int checks;
  int failures;

  fifo_pkt_drain_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

  fifo_pkt_drain #(
    .DATA_WIDTH(64),
    .CTRL_WIDTH(8),
    .HDR_CTRL(8'hFF),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .in_pkt(in_pkt),
    .pkt_done(pkt_done),
    .err(err),
    .stats_clr(stats_clr),
    .pkt_cnt(pkt_cnt),
    .word_cnt(word_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ex(input int v);
    return STATS ? 4'(v) : 4'd0;
  endfunction

  function automatic vec_t mk(
    input logic rst, input logic emp, input logic [7:0] ctrl,
    input logic rdy, input logic e_rd, input logic e_wr,
    input logic e_done, input logic e_err, input logic e_inp);
    vec_t v;
    v.rst = rst; v.emp = emp; v.ctrl = ctrl; v.data = '0;
    v.rdy = rdy; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_done = e_done; v.e_err = e_err; v.e_inp = e_inp;
    v.ck = 1'b0; v.pc = 0; v.wc = 0; v.dc = 0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    bus.fifo_dout  = {v.ctrl, v.data};
    bus.fifo_empty = v.emp;
    bus.out_rdy    = v.rdy;
    reset          = v.rst;
    stats_clr      = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_rd_en", idx), 72'(bus.fifo_rd_en), 72'(v.e_rd));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_out_wr", idx), 72'(bus.out_wr), 72'(v.e_wr));
    chk($sformatf("v%0d_done", idx), 72'(pkt_done), 72'(v.e_done));
    chk($sformatf("v%0d_err", idx), 72'(err), 72'(v.e_err));
    chk($sformatf("v%0d_in_pkt", idx), 72'(in_pkt), 72'(v.e_inp));
    if (v.e_wr) begin
      chk($sformatf("v%0d_data", idx), 72'(bus.out_data), 72'(v.data));
      chk($sformatf("v%0d_ctrl", idx), 72'(bus.out_ctrl), 72'(v.ctrl));
    end
    if (v.ck) begin
      chk($sformatf("v%0d_pkt_cnt", idx), 72'(pkt_cnt), 72'(ex(v.pc)));
      chk($sformatf("v%0d_word_cnt", idx), 72'(word_cnt), 72'(ex(v.wc)));
      chk($sformatf("v%0d_drop_cnt", idx), 72'(drop_cnt), 72'(ex(v.dc)));
    end
  endtask

  task automatic cyc(input logic rst, input logic emp,
                     input logic [7:0] ctrl, input logic clr);
    bus.fifo_dout  = {ctrl, 64'h0000_BEEF_0000_0000 | 64'(ctrl)};
    bus.fifo_empty = emp;
    bus.out_rdy    = 1'b1;
    reset          = rst;
    stats_clr      = clr;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[36];

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0]  = mk(1, 0, 8'hFF, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8'hFF, 1, 1, 1, 0, 0, 1);
    tbl[2]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[3]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 8'h80, 1, 1, 1, 1, 0, 0);
    tbl[5]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 8'hFF, 1, 1, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[8]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 8'h80, 1, 1, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 8'h01, 1, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 8'hFF, 1, 1, 1, 0, 0, 1);
    tbl[17] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[18] = mk(0, 0, 8'h80, 1, 1, 1, 1, 0, 0);
    tbl[19] = mk(0, 0, 8'hFF, 1, 1, 1, 0, 0, 1);
    tbl[20] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[21] = mk(0, 0, 8'hFF, 1, 1, 1, 0, 1, 1);
    tbl[22] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[23] = mk(0, 0, 8'h02, 1, 1, 1, 1, 0, 0);
    tbl[24] = mk(0, 0, 8'hFF, 1, 1, 1, 0, 0, 1);
    tbl[25] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[26] = mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    tbl[27] = mk(0, 0, 8'h00, 1, 1, 0, 0, 1, 0);
    tbl[28] = mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    tbl[29] = mk(0, 0, 8'h04, 1, 1, 0, 0, 0, 0);
    tbl[30] = mk(0, 0, 8'hFF, 1, 1, 1, 0, 0, 1);
    tbl[31] = mk(0, 0, 8'h80, 1, 1, 1, 1, 0, 0);
    tbl[32] = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 0);
    tbl[33] = mk(0, 0, 8'h05, 1, 1, 0, 0, 1, 0);
    tbl[34] = mk(0, 0, 8'h07, 1, 1, 0, 0, 1, 0);
    tbl[35] = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++) begin
      tbl[i].data = {32'hC0DE_0000, 32'(i)};
    end
    tbl[5].ck  = 1'b1; tbl[5].pc  = 1; tbl[5].wc  = 4;  tbl[5].dc  = 0;
    tbl[25].ck = 1'b1; tbl[25].pc = 4; tbl[25].wc = 18; tbl[25].dc = 1;
    tbl[26].ck = 1'b1; tbl[26].pc = 0; tbl[26].wc = 0;  tbl[26].dc = 0;
    tbl[35].ck = 1'b1; tbl[35].pc = 1; tbl[35].wc = 2;  tbl[35].dc = 3;

    cyc(1, 0, 8'hFF, 1'b0);
    cyc(1, 0, 8'hFF, 1'b0);
    chk("rst_out_data", 72'(bus.out_data), 72'(0));
    chk("rst_out_ctrl", 72'(bus.out_ctrl), 72'(0));
    chk("rst_out_wr", 72'(bus.out_wr), 72'(0));
    chk("rst_pkt_cnt", 72'(pkt_cnt), 72'(0));

    for (int i = 0; i < 36; i++) begin
      apply(tbl[i], i);
    end

    cyc(0, 0, 8'hFF, 1'b0);
    cyc(0, 1, 8'h00, 1'b0);
    cyc(0, 1, 8'h00, 1'b0);
    chk("drain_hold_in_pkt", 72'(in_pkt), 72'(1));
    chk("drain_hold_wr", 72'(bus.out_wr), 72'(0));
    cyc(0, 0, 8'h80, 1'b0);
    chk("drain_hold_done", 72'(pkt_done), 72'(1));

    cyc(0, 1, 8'h00, 1'b1);
    chk("clr_pkt_cnt", 72'(pkt_cnt), 72'(0));
    chk("clr_word_cnt", 72'(word_cnt), 72'(0));
    chk("clr_drop_cnt", 72'(drop_cnt), 72'(0));
    for (int k = 0; k < 17; k++) begin
      cyc(0, 0, 8'hFF, 1'b0);
      cyc(0, 0, 8'h81, 1'b0);
    end
    chk("wrap_pkt_cnt", 72'(pkt_cnt), 72'(ex(1)));
    chk("wrap_word_cnt", 72'(word_cnt), 72'(ex(2)));
    chk("wrap_done", 72'(pkt_done), 72'(1));

    cyc(0, 0, 8'hFF, 1'b0);
    cyc(0, 0, 8'h81, 1'b1);
    chk("clr_prio_done", 72'(pkt_done), 72'(1));
    chk("clr_prio_pkt_cnt", 72'(pkt_cnt), 72'(0));
    chk("clr_prio_word_cnt", 72'(word_cnt), 72'(0));
    cyc(0, 1, 8'h00, 1'b0);
    chk("after_clr_pkt_cnt", 72'(pkt_cnt), 72'(0));
    chk("after_clr_done", 72'(pkt_done), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_drain.md
# fifo_pkt_drain

Packet drain stage directly downstream of the first-word-fallthrough small FIFO. It pops 72-bit {ctrl, data} words whenever the FIFO is non-empty and the next module is ready. It tracks packet framing: module header, payload, end of packet. Malformed leading fragments are discarded, and well-formed words are forwarded on the standard out_wr/out_rdy pipeline bus with one-cycle registered latency.

## Interface
- DATA_WIDTH, 64, data bits per word
- CTRL_WIDTH, 8, ctrl bits per word (DATA_WIDTH/8)
- HDR_CTRL, 8'hFF, ctrl value that marks a module-header word
- CNT_WIDTH, 32, width of statistics counters

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fifo_dout  in  CTRL_WIDTH+DATA_WIDTH  FIFO head word; ctrl in the upper CTRL_WIDTH bits; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop FIFO head (combinational)
- out_data  out  DATA_WIDTH  forwarded data (registered)
- out_ctrl  out  CTRL_WIDTH  forwarded ctrl (registered)
- out_wr  out  1  out_data/out_ctrl valid this cycle
- out_rdy  in  1  downstream can accept a word next cycle
- in_pkt  out  1  state is HDR or PAYLOAD
- pkt_done  out  1  one-cycle pulse, coincident with out_wr of an EOP word
- err  out  1  one-cycle pulse on a framing error
- stats_clr  in  1  synchronous clear of counters
- pkt_cnt, word_cnt, drop_cnt  out  CNT_WIDTH each  statistics

## Operation
- Word classes on head ctrl: HDR if ctrl==HDR_CTRL; DATA if ctrl==0; EOP otherwise.
- discard = (state==IDLE && class!=HDR) || (state==DROP && class!=HDR).
- fifo_rd_en = !reset && !fifo_empty && (out_rdy || discard).
- A transfer (fifo_rd_en=1) forwards the word unless discard.
- Discarded words do not wait on out_rdy.
- FSM, advancing only on a transfer:
  - IDLE: HDR -> HDR, forward. DATA -> DROP, discard, err, drop_cnt+1. EOP -> stay IDLE, discard, err, drop_cnt+1.
  - HDR: HDR -> stay. DATA -> PAYLOAD. EOP -> IDLE with pkt_done. All forwarded.
  - PAYLOAD: DATA -> stay. EOP -> IDLE with pkt_done. HDR -> HDR with err (truncated packet). All forwarded.
  - DROP: DATA -> stay, discard. EOP -> IDLE, discard. HDR -> HDR, forward.
- pkt_cnt +1 per pkt_done. word_cnt +1 per forwarded word. Counters wrap modulo 2^CNT_WIDTH.
- stats_clr forces all counters to 0 and has priority over any increment in the same cycle.

## Timing
- Reset values: state IDLE, out_wr 0, out_data 0, out_ctrl 0, pkt_done 0, err 0, in_pkt 0, counters 0. fifo_rd_en is 0 while reset=1.
- Latency: a word popped in cycle N appears on out_data/out_ctrl with out_wr=1 in cycle N+1.
- pkt_done and err are registered and aligned to cycle N+1.
- Throughput is one word per cycle while out_rdy=1 and the FIFO is non-empty.
- out_rdy=0 stalls forwarding within one cycle; the word is held in the FIFO, never in this block.
- Reset mid-packet: the FSM returns to IDLE and the packet remainder is discarded via the DROP/IDLE path; err pulses once at its first word.
- When the FIFO drains mid-packet, the FSM holds state with no pops; there is no timeout.

## Configuration
- FIFO_PKT_DRAIN_STATS_EN defined: pkt_cnt, word_cnt and drop_cnt are implemented as specified.
- FIFO_PKT_DRAIN_STATS_EN undefined: the three counters are constant 0, stats_clr is ignored, and no counter flops are synthesised. Forwarding, err and pkt_done are unchanged.

## Test plan
- Basic packet, out_rdy=1: push FF/hdr, 00/d0, 00/d1, 80/d2. Required: four consecutive out_wr, each one cycle after its pop. pkt_done with the 80 word. pkt_cnt=1, word_cnt=4.
- Backpressure: same packet with out_rdy low for 3 cycles after word 2. Required: fifo_rd_en=0 during the stall, no out_wr gaps beyond the stall, word order intact.
- Orphan fragment: push 00/x, 00/y, 01/z, then a good 3-word packet. Required: first three words popped without out_wr, one err pulse, drop_cnt=1. Good packet forwarded, pkt_cnt=1.
- Truncated packet: FF, 00, FF, 00, 02. Required: all five forwarded, err pulse with the second FF, one pkt_done.
- Reset mid-packet: assert reset after FF, 00 of a 5-word packet. Required: outputs return to reset values. Remaining 00, 00, 04 discarded with one err. Next FF packet forwarded normally.
- Counter wrap and clear (CNT_WIDTH=4): send 17 single-header+EOP packets. Required: pkt_cnt=1. Asserting stats_clr in the same cycle as a pkt_done leaves pkt_cnt=0.
